if_fetch_stage: RTL and testbench
=================================

// Module: if_fetch_stage
// PURPOSE
//  IF stage of the 5-stage MIPS pipeline: owns the PC, drives instruction memory, and
//  holds the IF/ID pipeline register feeding ID. Consumes the ID-stage branch-compare
//  result (branch_taken) and jump target to redirect fetch and squash wrong-path
//  instructions. Tolerates multi-cycle imem latency via a ready handshake with timeout.
// PARAMETERS
//  RESET_PC  32'h0000_3000  PC value loaded on reset
//  WAIT_MAX  16             max consecutive not-ready cycles before fetch_err (>=1)
// PORTS
//  clk            in   1   clock, rising edge
//  rst_n          in   1   asynchronous active-low reset
//  stall          in   1   hazard-unit stall: hold PC and IF/ID
//  branch_taken   in   1   ID branch condition result (1 = taken)
//  branch_target  in   32  ID-computed branch target
//  jump           in   1   ID decoded J/JAL
//  jump_target    in   32  ID-computed jump target
//  imem_rdata     in   32  instruction word for imem_addr
//  imem_ready     in   1   imem_rdata valid this cycle
//  imem_req       out  1   fetch request
//  imem_addr      out  32  fetch address (= pc, [1:0] always 0)
//  ifid_instr     out  32  IF/ID instruction (32'h0 = NOP when invalid)
//  ifid_pc4       out  32  IF/ID PC+4
//  ifid_valid     out  1   IF/ID holds a real instruction
//  fetch_err      out  1   sticky imem timeout flag
// BEHAVIOUR
//  - Reset (async, rst_n=0): pc=RESET_PC, imem_req=0, ifid_instr=0, ifid_pc4=0,
//    ifid_valid=0, fetch_err=0, wait_cnt=0, redir_pend=0, state=BOOT.
//  - FSM: BOOT -> FETCH (one cycle, imem_req rises); FETCH -> FETCH; FETCH -> ERR when
//    wait_cnt reaches WAIT_MAX; ERR sticky until reset (imem_req=0, fetch_err=1, IF/ID=NOP).
//  - FETCH: imem_req=1, imem_addr=pc. wait_cnt increments per not-ready cycle, clears on ready.
//  - Redirect: branch_taken has priority over jump; target[1:0] forced to 0.
//  - Priority each cycle: stall > redirect > sequential.
//    stall=1: pc, IF/ID, redir_pend hold; branch_taken/jump ignored (ID re-presents them).
//    redirect & ready: pc<=target; IF/ID per delay-slot rule below.
//    redirect & !ready: latch target in redir_pend; PC unchanged until ready.
//    ready, no redirect: IF/ID<={imem_rdata, pc+4, valid=1}; pc<=redir_pend?pend_tgt:pc+4;
//      redir_pend cleared.
//    !ready, no stall: IF/ID<=NOP (valid=0, instr=0, pc4 unchanged).
//  - Latency: instruction at pc appears on ifid_* the edge after imem_ready=1.
//  - pc+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 32'h0).
//  - Redirect and ready in the same cycle as wait_cnt hits WAIT_MAX: ready wins, no error.
// CONFIGURATION
//  BRANCH_DELAY_SLOT_EN defined: fetch completing in the redirect cycle is the delay slot
//    and is latched into IF/ID with valid=1; with redir_pend, the in-flight word is kept
//    and the next fetch is from the target.
//  undefined: that word is wrong-path; IF/ID<=NOP (valid=0); a pending redirect discards
//    the in-flight word on ready and fetches from the target.
// TESTING
//  1 reset, imem_ready=1 always, words A,B,C -> ifid_instr A,B,C on edges 2,3,4;
//    ifid_pc4 = 3004,3008,300C.
//  2 branch_taken=1, target 32'h3100, ready=1 -> next imem_addr=3100; IF/ID NOP
//    (no macro) or delay-slot word valid=1 (macro).
//  3 stall=1 for 3 cycles with branch_taken=1 -> pc, ifid_* unchanged; no redirect
//    taken during stall.
//  4 imem_ready=0 for WAIT_MAX cycles -> fetch_err=1, imem_req=0, stays until rst_n=0.
//  5 pc=32'hFFFF_FFFC, sequential fetch -> ifid_pc4=0, next imem_addr=0.
//  6 branch_taken and jump together, ready=0 then 1 -> fetch resumes at branch_target.

Source files
------------

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory port of the IF stage.
// The fetch stage is the master: it raises imem_req with imem_addr.
// The memory is the slave: it answers with imem_rdata and imem_ready.
//
// Handshake: while imem_req is 1, the master holds imem_addr stable until it
// samples imem_ready=1 on a rising clk edge. That edge completes the transfer,
// and imem_rdata is the word at imem_addr in that same cycle. The slave may
// hold imem_ready low for any number of cycles. The master bounds that wait
// with its own timeout. imem_ready has no meaning while imem_req is 0.
interface if_fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  imem_ready
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output imem_ready
  );
endinterface

// File: rtl/if_fetch_stage.sv
// IF stage of the 5-stage MIPS pipeline.
// The stage owns the PC and drives instruction memory through the
// if_fetch_stage_if master modport. It holds the IF/ID register that feeds ID.
// It takes branch and jump redirects resolved in ID. It squashes wrong-path
// words, or keeps the delay slot when that option is built in. An imem stall
// longer than WAIT_MAX cycles raises a sticky fetch_err.
//
// Build option: define BRANCH_DELAY_SLOT_EN to keep the word fetched in the
// redirect cycle as an architectural delay slot. It then enters IF/ID with
// valid=1. When the macro is undefined, that word is squashed and IF/ID gets
// a NOP.
//
// dbg_state shows the FSM state: 0 = BOOT, 1 = FETCH, 2 = ERR.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          WAIT_MAX = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    stall,
  input  logic                    branch_taken,
  input  logic [31:0]             branch_target,
  input  logic                    jump,
  input  logic [31:0]             jump_target,
  if_fetch_stage_if.master        imem_bus,
  output logic [31:0]             ifid_instr,
  output logic [31:0]             ifid_pc4,
  output logic                    ifid_valid,
  output logic                    fetch_err,
  output logic [1:0]              dbg_state
);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_ERR   = 2'd2
  } state_e;

  // The counter must be able to hold WAIT_MAX itself.
  localparam int          CW       = $clog2(WAIT_MAX + 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(WAIT_MAX - 1);
  localparam logic [CW-1:0] WAIT_LIM  = CW'(WAIT_MAX);

`ifdef BRANCH_DELAY_SLOT_EN
  localparam bit KEEP_SLOT = 1'b1;
`else
  localparam bit KEEP_SLOT = 1'b0;
`endif

  state_e        state, state_nxt;
  logic [31:0]   pc, pc_nxt;
  logic [31:0]   instr_nxt, pc4_nxt;
  logic          valid_nxt;
  logic          redir_pend, pend_nxt;
  logic [31:0]   pend_tgt, pend_tgt_nxt;
  logic [CW-1:0] wait_cnt, cnt_nxt;
  logic          err_nxt;

  logic          ready;
  logic          redir;
  logic [31:0]   redir_tgt;
  logic [31:0]   pc_plus4;
  logic          timeout;

  assign ready    = imem_bus.imem_ready;
  assign pc_plus4 = pc + 32'd4;

  // A taken branch outranks a jump when both are presented.
  // Targets are forced to word alignment.
  assign redir     = branch_taken | jump;
  assign redir_tgt = (branch_taken ? branch_target : jump_target) & ~32'h3;

  // A not-ready cycle that would bring the counter to WAIT_MAX is the timeout.
  // A ready cycle clears the counter instead, so ready always wins.
  assign timeout = (state == ST_FETCH) && !ready && (wait_cnt == WAIT_LAST);

  // The request is raised in FETCH only. The address is always the PC.
  assign imem_bus.imem_req  = (state == ST_FETCH);
  assign imem_bus.imem_addr = pc;
  assign dbg_state          = state;

  // Next-state and next-register values. Every target holds by default.
  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    instr_nxt    = ifid_instr;
    pc4_nxt      = ifid_pc4;
    valid_nxt    = ifid_valid;
    pend_nxt     = redir_pend;
    pend_tgt_nxt = pend_tgt;
    cnt_nxt      = wait_cnt;
    err_nxt      = fetch_err;

    case (state)
      ST_BOOT: begin
        state_nxt = ST_FETCH;
      end

      ST_FETCH: begin
        // The imem timeout runs whether or not the pipeline is stalled.
        if (ready) begin
          cnt_nxt = '0;
        end else if (timeout) begin
          cnt_nxt = WAIT_LIM;
        end else begin
          cnt_nxt = wait_cnt + 1'b1;
        end

        if (timeout) begin
          state_nxt = ST_ERR;
          err_nxt   = 1'b1;
          instr_nxt = 32'h0;
          valid_nxt = 1'b0;
        end else if (!stall) begin
          if (redir) begin
            if (ready) begin
              // The redirect completes now. The word in flight is the delay slot.
              pc_nxt   = redir_tgt;
              pend_nxt = 1'b0;
              if (KEEP_SLOT) begin
                instr_nxt = imem_bus.imem_rdata;
                pc4_nxt   = pc_plus4;
                valid_nxt = 1'b1;
              end else begin
                instr_nxt = 32'h0;
                valid_nxt = 1'b0;
              end
            end else begin
              // Memory is busy. Remember the target and keep fetching at the PC.
              pend_nxt     = 1'b1;
              pend_tgt_nxt = redir_tgt;
              instr_nxt    = 32'h0;
              valid_nxt    = 1'b0;
            end
          end else if (ready) begin
            if (redir_pend) begin
              pc_nxt   = pend_tgt;
              pend_nxt = 1'b0;
              if (KEEP_SLOT) begin
                instr_nxt = imem_bus.imem_rdata;
                pc4_nxt   = pc_plus4;
                valid_nxt = 1'b1;
              end else begin
                instr_nxt = 32'h0;
                valid_nxt = 1'b0;
              end
            end else begin
              pc_nxt    = pc_plus4;
              instr_nxt = imem_bus.imem_rdata;
              pc4_nxt   = pc_plus4;
              valid_nxt = 1'b1;
            end
          end else begin
            // No word this cycle. Send a bubble and keep pc4.
            instr_nxt = 32'h0;
            valid_nxt = 1'b0;
          end
        end
      end

      ST_ERR: begin
        err_nxt   = 1'b1;
        instr_nxt = 32'h0;
        valid_nxt = 1'b0;
      end

      default: begin
        state_nxt = ST_BOOT;
      end
    endcase
  end

  // State register, PC, IF/ID register, pending redirect and timeout counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_BOOT;
      pc         <= RESET_PC;
      ifid_instr <= 32'h0;
      ifid_pc4   <= 32'h0;
      ifid_valid <= 1'b0;
      redir_pend <= 1'b0;
      pend_tgt   <= 32'h0;
      wait_cnt   <= '0;
      fetch_err  <= 1'b0;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      ifid_instr <= instr_nxt;
      ifid_pc4   <= pc4_nxt;
      ifid_valid <= valid_nxt;
      redir_pend <= pend_nxt;
      pend_tgt   <= pend_tgt_nxt;
      wait_cnt   <= cnt_nxt;
      fetch_err  <= err_nxt;
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage.
// The memory model returns addr + 32'h1000_0000 as the instruction word.
// Expected IF/ID contents are pushed as {valid, instr, pc4} whenever a fetch
// completes. A monitor pops and compares them on the cycle the new value shows.
module tb_if_fetch_stage;
  localparam int WAIT_MAX = 16;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc4;
  logic        ifid_valid;
  logic        fetch_err;
  logic [1:0]  dbg_state;
  logic        rdy;

  int total;
  int bad;

  logic [64:0] exp_q[$];
  logic        upd_pend;

  if_fetch_stage_if imem_bus();

  if_fetch_stage #(
    .RESET_PC (32'h0000_3000),
    .WAIT_MAX (WAIT_MAX)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .imem_bus      (imem_bus),
    .ifid_instr    (ifid_instr),
    .ifid_pc4      (ifid_pc4),
    .ifid_valid    (ifid_valid),
    .fetch_err     (fetch_err),
    .dbg_state     (dbg_state)
  );

  // Instruction memory model
  assign imem_bus.imem_ready = rdy;
  assign imem_bus.imem_rdata = imem_bus.imem_addr + 32'h1000_0000;

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic v, input logic [31:0] instr, input logic [31:0] pc4);
    exp_q.push_back({v, instr, pc4});
  endtask

  // Monitor: a fetch completes when req, ready and no stall are seen together.
  // The result shows on IF/ID one negedge later.
  always @(negedge clk) begin
    logic [64:0] e;
    if (!rst_n) begin
      upd_pend = 1'b0;
    end else begin
      if (upd_pend) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL ifid_unexpected: got valid=%0b instr=%h pc4=%h expected none",
                   ifid_valid, ifid_instr, ifid_pc4);
        end else begin
          e = exp_q.pop_front();
          check("ifid_valid", {31'h0, ifid_valid}, {31'h0, e[64]});
          check("ifid_instr", ifid_instr, e[63:32]);
          check("ifid_pc4", ifid_pc4, e[31:0]);
        end
      end
      upd_pend = imem_bus.imem_req && rdy && !stall;
    end
  end

  task automatic check_reset_state();
    check("rst_imem_addr", imem_bus.imem_addr, 32'h3000);
    check("rst_imem_req", {31'h0, imem_bus.imem_req}, 32'h0);
    check("rst_ifid_instr", ifid_instr, 32'h0);
    check("rst_ifid_pc4", ifid_pc4, 32'h0);
    check("rst_ifid_valid", {31'h0, ifid_valid}, 32'h0);
    check("rst_fetch_err", {31'h0, fetch_err}, 32'h0);
    check("rst_state", {30'h0, dbg_state}, 32'h0);
  endtask

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // Stimulus
  initial begin
    total         = 0;
    bad           = 0;
    upd_pend      = 1'b0;
    rst_n         = 1'b0;
    stall         = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 32'h0;
    jump          = 1'b0;
    jump_target   = 32'h0;
    rdy           = 1'b1;

    repeat (2) tick();
    check_reset_state();
    rst_n = 1'b1;

    // 1: sequential fetch. A, B and C show on edges 2, 3 and 4.
    check("boot_req", {31'h0, imem_bus.imem_req}, 32'h0);
    push(1'b1, 32'h1000_3000, 32'h3004);
    push(1'b1, 32'h1000_3004, 32'h3008);
    push(1'b1, 32'h1000_3008, 32'h300C);
    tick();
    check("fetch_req", {31'h0, imem_bus.imem_req}, 32'h1);
    check("fetch_addr0", imem_bus.imem_addr, 32'h3000);
    repeat (3) tick();

    // 2: taken branch with ready. Target bits [1:0] are dropped.
    branch_taken  = 1'b1;
    branch_target = 32'h0000_3103;
`ifdef BRANCH_DELAY_SLOT_EN
    push(1'b1, 32'h1000_300C, 32'h3010);
`else
    push(1'b0, 32'h0, 32'h300C);
`endif
    tick();
    branch_taken = 1'b0;
    check("branch_addr", imem_bus.imem_addr, 32'h3100);
    push(1'b1, 32'h1000_3100, 32'h3104);
    tick();

    // 3: a three-cycle stall with branch_taken held high. No redirect is taken.
    stall         = 1'b1;
    branch_taken  = 1'b1;
    branch_target = 32'h3200;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_addr", imem_bus.imem_addr, 32'h3104);
      check("stall_instr", ifid_instr, 32'h1000_3100);
      check("stall_pc4", ifid_pc4, 32'h3104);
    end
    stall        = 1'b0;
    branch_taken = 1'b0;
    push(1'b1, 32'h1000_3104, 32'h3108);
    tick();

    // 6: branch and jump together while not ready. The branch target wins.
    branch_taken  = 1'b1;
    branch_target = 32'h3400;
    jump          = 1'b1;
    jump_target   = 32'h3500;
    rdy           = 1'b0;
    tick();
    check("pend_valid", {31'h0, ifid_valid}, 32'h0);
    check("pend_instr", ifid_instr, 32'h0);
    check("pend_pc4", ifid_pc4, 32'h3108);
    check("pend_addr", imem_bus.imem_addr, 32'h3108);
    branch_taken = 1'b0;
    jump         = 1'b0;
    rdy          = 1'b1;
`ifdef BRANCH_DELAY_SLOT_EN
    push(1'b1, 32'h1000_3108, 32'h310C);
`else
    push(1'b0, 32'h0, 32'h3108);
`endif
    tick();
    check("pend_resume_addr", imem_bus.imem_addr, 32'h3400);
    push(1'b1, 32'h1000_3400, 32'h3404);
    tick();

    // 5: jump to the top word. The sequential PC then wraps to 0.
    jump        = 1'b1;
    jump_target = 32'hFFFF_FFFC;
`ifdef BRANCH_DELAY_SLOT_EN
    push(1'b1, 32'h1000_3404, 32'h3408);
`else
    push(1'b0, 32'h0, 32'h3404);
`endif
    tick();
    jump = 1'b0;
    check("jump_addr", imem_bus.imem_addr, 32'hFFFF_FFFC);
    push(1'b1, 32'h0FFF_FFFC, 32'h0);
    tick();
    check("wrap_addr", imem_bus.imem_addr, 32'h0);

    // wait_cnt is cleared by a ready cycle just short of the limit.
    rdy = 1'b0;
    repeat (WAIT_MAX - 1) tick();
    check("near_limit_err", {31'h0, fetch_err}, 32'h0);
    rdy = 1'b1;
    push(1'b1, 32'h1000_0000, 32'h4);
    tick();

    // 4: WAIT_MAX not-ready cycles in a row give the sticky error.
    rdy = 1'b0;
    repeat (WAIT_MAX - 1) tick();
    check("pre_timeout_err", {31'h0, fetch_err}, 32'h0);
    check("pre_timeout_state", {30'h0, dbg_state}, 32'h1);
    tick();
    check("timeout_err", {31'h0, fetch_err}, 32'h1);
    check("timeout_req", {31'h0, imem_bus.imem_req}, 32'h0);
    check("timeout_valid", {31'h0, ifid_valid}, 32'h0);
    check("timeout_state", {30'h0, dbg_state}, 32'h2);
    rdy = 1'b1;
    repeat (5) tick();
    check("sticky_err", {31'h0, fetch_err}, 32'h1);
    check("sticky_req", {31'h0, imem_bus.imem_req}, 32'h0);
    check("sticky_instr", ifid_instr, 32'h0);

    // Asynchronous reset clears the error without waiting for a clock edge.
    rst_n = 1'b0;
    #2;
    check_reset_state();

    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
